// File: rtl/approx_mul_ha_pipe_pkg.sv
// Shared constants and sizing helpers for the half-adder-array approximate multiplier.
package approx_mul_ha_pipe_pkg;

    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_APPROX = 1'b1;

    localparam int unsigned CNT_W = 16;

    // Operand bits are consumed two at a time, one half-adder array per pair.
    function automatic int unsigned pair_cnt(input int unsigned width);
        return width / 2;
    endfunction

    function automatic int unsigned t_width(input int unsigned width);
        return width + 1;
    endfunction

    function automatic int unsigned b_width(input int unsigned width);
        return width - 1;
    endfunction

    function automatic int unsigned prod_width(input int unsigned width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/approx_mul_ha_pipe_pair.sv
// Half-adder array merging two adjacent partial-product rows; low columns may be OR-approximated.
module approx_ha_pair
    import approx_mul_ha_pipe_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned APPROX_COLS = 4
) (
    input  logic [WIDTH-1:0]          row_a,
    input  logic [WIDTH-1:0]          row_b,
    input  logic                      mode,
    output logic [t_width(WIDTH)-1:0] t,
    output logic [b_width(WIDTH)-1:0] b
);

    // Column j adds row_a[j] and row_b[j-1]; the carry lands two columns up in b.
    always_comb begin
        t        = '0;
        b        = '0;
        t[0]     = row_a[0];
        t[WIDTH] = row_b[WIDTH-1];
        for (int unsigned j = 1; j < WIDTH; j++) begin
            if ((mode == MODE_APPROX) && (j < APPROX_COLS)) begin
                t[j]   = row_a[j] | row_b[j-1];
                b[j-1] = 1'b0;
            end else begin
                t[j]   = row_a[j] ^ row_b[j-1];
                b[j-1] = row_a[j] & row_b[j-1];
            end
        end
    end

endmodule

// File: rtl/approx_mul_ha_pipe.sv
// Three-stage approximate/exact unsigned multiplier with a single global advance enable.
module approx_mul_ha_pipe
    import approx_mul_ha_pipe_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned APPROX_COLS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         x,
    input  logic [WIDTH-1:0]         y,
    input  logic                     mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*WIDTH-1:0]       product,
    output logic                     out_mode,
    output logic [15:0]              approx_cnt
);

    localparam int unsigned PAIRS = pair_cnt(WIDTH);
    localparam int unsigned TW    = t_width(WIDTH);
    localparam int unsigned BW    = b_width(WIDTH);
    localparam int unsigned PW    = prod_width(WIDTH);

    logic adv_en;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_x_q,     s1_x_d;
    logic [WIDTH-1:0] s1_y_q,     s1_y_d;
    logic             s1_mode_q,  s1_mode_d;

    logic             s2_valid_q, s2_valid_d;
    logic             s2_mode_q,  s2_mode_d;
    logic [TW-1:0]    s2_t_q [PAIRS];
    logic [TW-1:0]    s2_t_d [PAIRS];
    logic [BW-1:0]    s2_b_q [PAIRS];
    logic [BW-1:0]    s2_b_d [PAIRS];
    logic [TW-1:0]    pair_t [PAIRS];
    logic [BW-1:0]    pair_b [PAIRS];

    logic             s3_valid_q, s3_valid_d;
    logic [PW-1:0]    s3_prod_q,  s3_prod_d;
    logic             s3_mode_q,  s3_mode_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    logic [PW-1:0]    prod_sum;

    // One half-adder array per operand bit pair, fed from the S1 operands.
    for (genvar k = 0; k < PAIRS; k++) begin : g_pair
        logic [WIDTH-1:0] row_a;
        logic [WIDTH-1:0] row_b;

        assign row_a = s1_y_q & {WIDTH{s1_x_q[2*k]}};
        assign row_b = s1_y_q & {WIDTH{s1_x_q[2*k+1]}};

        approx_ha_pair #(
            .WIDTH       (WIDTH),
            .APPROX_COLS (APPROX_COLS)
        ) u_pair (
            .row_a (row_a),
            .row_b (row_b),
            .mode  (s1_mode_q),
            .t     (pair_t[k]),
            .b     (pair_b[k])
        );
    end

    // Final accumulation of the registered pair sums; pair k carries weight 4^k.
    always_comb begin
        prod_sum = '0;
        for (int unsigned k = 0; k < PAIRS; k++) begin
            prod_sum = prod_sum
                     + (PW'(s2_t_q[k]) << (2 * k))
                     + (PW'(s2_b_q[k]) << (2 * k + 2));
        end
    end

    assign adv_en = !s3_valid_q || out_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s1_mode_d  = s1_mode_q;
        s2_valid_d = s2_valid_q;
        s2_mode_d  = s2_mode_q;
        s2_t_d     = s2_t_q;
        s2_b_d     = s2_b_q;
        s3_valid_d = s3_valid_q;
        s3_prod_d  = s3_prod_q;
        s3_mode_d  = s3_mode_q;
        cnt_d      = cnt_q;

        if (adv_en) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_x_d    = x;
                s1_y_d    = y;
                s1_mode_d = mode;
            end
            s2_valid_d = s1_valid_q;
            s2_mode_d  = s1_mode_q;
            s2_t_d     = pair_t;
            s2_b_d     = pair_b;
            s3_valid_d = s2_valid_q;
            // Bubbles leave the last delivered result visible on the output.
            if (s2_valid_q) begin
                s3_prod_d = prod_sum;
                s3_mode_d = s2_mode_q;
            end
        end

        if (s3_valid_q && out_ready && (s3_mode_q == MODE_APPROX) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_mode_q  <= MODE_EXACT;
            s2_valid_q <= 1'b0;
            s2_mode_q  <= MODE_EXACT;
            for (int unsigned k = 0; k < PAIRS; k++) begin
                s2_t_q[k] <= '0;
                s2_b_q[k] <= '0;
            end
            s3_valid_q <= 1'b0;
            s3_prod_q  <= '0;
            s3_mode_q  <= MODE_EXACT;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s1_mode_q  <= s1_mode_d;
            s2_valid_q <= s2_valid_d;
            s2_mode_q  <= s2_mode_d;
            s2_t_q     <= s2_t_d;
            s2_b_q     <= s2_b_d;
            s3_valid_q <= s3_valid_d;
            s3_prod_q  <= s3_prod_d;
            s3_mode_q  <= s3_mode_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready   = adv_en;
    assign out_valid  = s3_valid_q;
    assign product    = s3_prod_q;
    assign out_mode   = s3_mode_q;
    assign approx_cnt = cnt_q;

endmodule

// File: tb/tb_approx_mul_ha_pipe.sv
// Scoreboard bench for approx_mul_ha_pipe: directed scenarios plus random traffic and backpressure.
module tb_approx_mul_ha_pipe;

    localparam int WIDTH = 8;
    localparam int AC    = 4;
    localparam int MASK  = ((1 << AC) - 1) & ~1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        out_mode;
    logic [15:0] approx_cnt;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [16:0] sb[$];
    logic [16:0] sb_e;
    logic [15:0] exp_cnt    = '0;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_prod;
    logic        prev_mode;
    bit          bp_en      = 1'b0;

    always #5 clk = ~clk;

    approx_mul_ha_pipe #(
        .WIDTH       (WIDTH),
        .APPROX_COLS (AC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .y          (y),
        .mode       (mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .product    (product),
        .out_mode   (out_mode),
        .approx_cnt (approx_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Approximate pair value = exact pair sum minus the dropped carries in the OR columns.
    function automatic logic [15:0] model(input logic [7:0] xx, input logic [7:0] yy, input logic m);
        int acc = 0;
        for (int k = 0; k < WIDTH / 2; k++) begin
            int a  = int'(yy & {8{xx[2*k]}});
            int b  = int'(yy & {8{xx[2*k+1]}});
            int pv = a + 2 * b;
            if (m) pv = pv - ((a & (b << 1)) & MASK);
            acc = acc + (pv << (2 * k));
        end
        return 16'(acc);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            exp_cnt    = '0;
            prev_stall = 1'b0;
        end else begin
            chk("approx_cnt", 32'(approx_cnt), 32'(exp_cnt));
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_product", 32'(product), 32'(prev_prod));
                chk("stall_mode", 32'(out_mode), 32'(prev_mode));
            end
            if (in_valid && in_ready) sb.push_back({mode, model(x, y, mode)});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    sb_e = sb.pop_front();
                    chk("product", 32'(product), 32'(sb_e[15:0]));
                    chk("out_mode", 32'(out_mode), 32'(sb_e[16]));
                    if (sb_e[16] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_prod  = product;
            prev_mode  = out_mode;
        end
    end

    always @(posedge clk) begin
        if (bp_en) begin
            #1;
            if (bp_en) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [7:0] xv, input logic [7:0] yv, input logic mv);
        bit ok = 1'b0;
        x        = xv;
        y        = yv;
        mode     = mv;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("send_timeout", 32'(ok), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bp_en = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) break;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        x         = '0;
        y         = '0;
        mode      = 1'b0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        chk("rst_approx_cnt", 32'(approx_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);
        chk("out_mode_after_reset", 32'(out_mode), 32'd0);
        @(posedge clk);
        #1;

        // Exact full-scale product and three-cycle latency.
        send(8'd255, 8'd255, 1'b0);
        @(negedge clk);
        chk("latency_c1", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("latency_c2", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("latency_c3", 32'(out_valid), 32'd1);
        chk("product_255x255", 32'(product), 32'd65025);
        @(posedge clk);
        #1;

        // Approximate collision in the low columns.
        send(8'd3, 8'd3, 1'b1);
        idle(4);
        @(negedge clk);
        chk("approx_3x3", 32'(product), 32'd7);
        chk("approx_3x3_mode", 32'(out_mode), 32'd1);
        chk("approx_cnt_1", 32'(approx_cnt), 32'd1);
        @(posedge clk);
        #1;

        // Approximate mode without a collision equals the exact product.
        send(8'd16, 8'd3, 1'b1);
        idle(4);
        @(negedge clk);
        chk("approx_16x3", 32'(product), 32'd48);
        chk("approx_cnt_2", 32'(approx_cnt), 32'd2);
        @(posedge clk);
        #1;

        // Four back-to-back beats against a five-cycle output stall.
        drain();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        x         = 8'd1;
        y         = 8'd10;
        mode      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bit acc;
            @(negedge clk);
            chk($sformatf("stall_in_ready_%0d", i), 32'(in_ready), (i < 3) ? 32'd1 : 32'd0);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) x = x + 8'd1;
        end
        out_ready = 1'b1;
        send(x, 8'd10, 1'b0);
        drain();

        // Reset with two beats in flight.
        send(8'd5, 8'd6, 1'b0);
        send(8'd7, 8'd8, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_approx_cnt", 32'(approx_cnt), 32'd0);
        chk("flush_product", 32'(product), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        idle(6);

        // Random operands, gaps and backpressure.
        bp_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(8'($urandom), 8'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain();

        // Counter saturation.
        for (int i = 0; i < 65540; i++) begin
            send(8'($urandom), 8'($urandom), 1'b1);
        end
        drain();
        @(negedge clk);
        chk("approx_cnt_saturated", 32'(approx_cnt), 32'd65535);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
